// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with majority-vote sampling, break and overrun
// detection, feeding a valid/ready frame FIFO.
module uart_rx_param #(
  parameter int DATA_BITS       = 8,
  parameter int PARITY_MODE     = 0,
  parameter int STOP_BITS       = 1,
  parameter int OVERSAMPLE_RATE = 16,
  parameter int SYSTEM_CLK      = 10000000,
  parameter int BAUD_RATE       = 9600,
  parameter int FLOPS           = 2,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_i_data,
  input  logic                          m_ready,
  output logic                          m_valid,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_parity_err,
  output logic                          m_frame_err,
  output logic                          m_break,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int DIV = SYSTEM_CLK / (BAUD_RATE * OVERSAMPLE_RATE);
  localparam int CW  = $clog2(DIV + 1);
  localparam int MID = OVERSAMPLE_RATE / 2;
  localparam int TW  = $clog2(OVERSAMPLE_RATE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = DATA_BITS + 3;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

  state_t              state_q, state_d;
  logic [FLOPS-1:0]    sync_q, sync_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                s0_q, s0_d, s1_q, s1_d, par_q, par_d, perr_q, perr_d;
  logic                ferr_q, ferr_d, stp_q, stp_d, push_q, push_d, ovr_q, ovr_d;
  logic [EW-1:0]       entry_q, entry_d;
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]         count_q, count_d;
  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic                rx_s, tick, vote, at_vote, ferr_n, brk, full, pop, wr;

  assign rx_s    = sync_q[FLOPS-1];
  assign tick    = cnt_q == CW'(DIV - 1);
  assign vote    = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign at_vote = tick && tcnt_q == TW'(MID + 1);
  assign ferr_n  = ferr_q | ~vote;
  assign brk     = ~|shreg_q & ~par_q & ferr_n;

  always_comb begin
    sync_d  = {sync_q[FLOPS-2:0], rx_i_data};
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    par_d   = par_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    stp_d   = stp_q;
    push_d  = 1'b0;
    entry_d = entry_q;
    if (tick) begin
      tcnt_d = (tcnt_q == TW'(OVERSAMPLE_RATE - 1)) ? '0 : tcnt_q + 1'b1;
      s0_d   = (tcnt_q == TW'(MID - 1)) ? rx_s : s0_q;
      s1_d   = (tcnt_q == TW'(MID)) ? rx_s : s1_q;
    end
    case (state_q)
      IDLE: if (tick && !rx_s) begin
        state_d = START;
        tcnt_d  = '0;
      end
      START: if (at_vote) begin
        state_d = vote ? IDLE : DATA;
        bit_d   = '0;
        par_d   = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        stp_d   = 1'b0;
      end
      DATA: if (at_vote) begin
        shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
        bit_d   = bit_q + 1'b1;
        if (bit_q == BW'(DATA_BITS - 1)) state_d = (PARITY_MODE != 0) ? PARITY : STOP;
      end
      PARITY: if (at_vote) begin
        par_d   = vote;
        perr_d  = ^shreg_q ^ vote ^ (PARITY_MODE == 1);
        state_d = STOP;
      end
      STOP: if (at_vote) begin
        ferr_d = ferr_n;
        stp_d  = 1'b1;
        if (stp_q == 1'(STOP_BITS - 1)) begin
          push_d  = 1'b1;
          entry_d = {brk, ferr_n, perr_q, shreg_q};
          // a break holds off new starts until the line has gone idle again
          state_d = brk ? BRK : IDLE;
        end
      end
      BRK: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    full    = count_q == (AW+1)'(FIFO_DEPTH);
    pop     = m_valid & m_ready;
    wr      = push_q & (~full | pop);
    wr_d    = wr_q + AW'(wr);
    rd_d    = rd_q + AW'(pop);
    count_d = count_q + (AW+1)'(wr) - (AW+1)'(pop);
    ovr_d   = push_q & full & ~pop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      state_q <= IDLE;
      tcnt_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      stp_q   <= 1'b0;
      push_q  <= 1'b0;
      entry_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      stp_q   <= stp_d;
      push_q  <= push_d;
      entry_q <= entry_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge clk) if (wr) mem[wr_q] <= entry_q;

  assign m_valid    = |count_q;
  assign {m_break, m_frame_err, m_parity_err, m_data} = m_valid ? mem[rd_q] : '0;
  assign overrun    = ovr_q;
  assign fifo_level = count_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed scenarios on an 8N1 depth-4 receiver (a) and an 8E1 depth-8 receiver (b).
module tb_uart_rx_param;
  localparam int BIT = 160;

  logic clk = 1'b0, rst_n = 1'b0;
  logic rx_a = 1'b1, rdy_a = 1'b0, rx_b = 1'b1, rdy_b = 1'b0;
  logic v_a, pe_a, fe_a, br_a, ov_a, v_b, pe_b, fe_b, br_b, ov_b;
  logic [7:0] d_a, d_b;
  logic [2:0] lvl_a;
  logic [3:0] lvl_b;
  logic [10:0] pops_a[$], pops_b[$];
  int ovr_a = 0, checks = 0, failures = 0;

  always #5 clk = ~clk;

  uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .OVERSAMPLE_RATE(16),
    .SYSTEM_CLK(1600000), .BAUD_RATE(10000), .FLOPS(2), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(rst_n), .rx_i_data(rx_a), .m_ready(rdy_a), .m_valid(v_a), .m_data(d_a),
    .m_parity_err(pe_a), .m_frame_err(fe_a), .m_break(br_a), .overrun(ov_a), .fifo_level(lvl_a));

  uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .OVERSAMPLE_RATE(16),
    .SYSTEM_CLK(1600000), .BAUD_RATE(10000), .FLOPS(2), .FIFO_DEPTH(8)) dut_b (
    .clk(clk), .reset(rst_n), .rx_i_data(rx_b), .m_ready(rdy_b), .m_valid(v_b), .m_data(d_b),
    .m_parity_err(pe_b), .m_frame_err(fe_b), .m_break(br_b), .overrun(ov_b), .fifo_level(lvl_b));

  always @(negedge clk) begin
    if (v_a && rdy_a) pops_a.push_back({br_a, fe_a, pe_a, d_a});
    if (v_b && rdy_b) pops_b.push_back({br_b, fe_b, pe_b, d_b});
    if (ov_a) ovr_a++;
  end

  function automatic logic [10:0] head_a(int i);
    return (i < pops_a.size()) ? pops_a[i] : 11'h7ff;
  endfunction

  function automatic logic [10:0] head_b(int i);
    return (i < pops_b.size()) ? pops_b[i] : 11'h7ff;
  endfunction

  task automatic send_a(input logic [7:0] d, input logic stop);
    rx_a = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_a = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx_a = stop;
    repeat (BIT) @(negedge clk);
    rx_a = 1'b1;
  endtask

  task automatic send_b(input logic [7:0] d, input logic p);
    rx_b = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_b = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx_b = p;
    repeat (BIT) @(negedge clk);
    rx_b = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    checks += 6;
    if (v_a !== 1'b0) begin failures++; $display("FAIL reset_valid_a got=%b exp=0", v_a); end
    if (lvl_a !== 3'd0) begin failures++; $display("FAIL reset_level_a got=%0d exp=0", lvl_a); end
    if ({br_a, fe_a, pe_a, d_a} !== 11'h0) begin failures++; $display("FAIL reset_data_a got=%h exp=0", {br_a, fe_a, pe_a, d_a}); end
    if (ov_a !== 1'b0) begin failures++; $display("FAIL reset_overrun_a got=%b exp=0", ov_a); end
    if (v_b !== 1'b0) begin failures++; $display("FAIL reset_valid_b got=%b exp=0", v_b); end
    if (lvl_b !== 4'd0) begin failures++; $display("FAIL reset_level_b got=%0d exp=0", lvl_b); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_basic;
    pops_a.delete();
    rdy_a = 1'b1;
    send_a(8'hA5, 1'b1);
    repeat (100) @(negedge clk);
    checks += 3;
    if (pops_a.size() !== 1) begin failures++; $display("FAIL basic_count got=%0d exp=1", pops_a.size()); end
    if (head_a(0) !== {3'b000, 8'hA5}) begin failures++; $display("FAIL basic_entry got=%h exp=%h", head_a(0), {3'b000, 8'hA5}); end
    if (lvl_a !== 3'd0) begin failures++; $display("FAIL basic_level got=%0d exp=0", lvl_a); end
  endtask

  task automatic test_parity;
    pops_b.delete();
    rdy_b = 1'b1;
    send_b(8'h07, 1'b0);
    send_b(8'h03, 1'b0);
    repeat (50) @(negedge clk);
    checks += 3;
    if (pops_b.size() !== 2) begin failures++; $display("FAIL parity_count got=%0d exp=2", pops_b.size()); end
    if (head_b(0) !== {3'b001, 8'h07}) begin failures++; $display("FAIL parity_bad got=%h exp=%h", head_b(0), {3'b001, 8'h07}); end
    if (head_b(1) !== {3'b000, 8'h03}) begin failures++; $display("FAIL parity_good got=%h exp=%h", head_b(1), {3'b000, 8'h03}); end
  endtask

  task automatic test_frame_err;
    pops_a.delete();
    send_a(8'h3C, 1'b0);
    repeat (400) @(negedge clk);
    checks += 2;
    if (pops_a.size() !== 1) begin failures++; $display("FAIL frame_count got=%0d exp=1", pops_a.size()); end
    if (head_a(0) !== {3'b010, 8'h3C}) begin failures++; $display("FAIL frame_entry got=%h exp=%h", head_a(0), {3'b010, 8'h3C}); end
  endtask

  task automatic test_break;
    pops_a.delete();
    rx_a = 1'b0;
    repeat (20 * BIT) @(negedge clk);
    rx_a = 1'b1;
    repeat (400) @(negedge clk);
    checks += 2;
    if (pops_a.size() !== 1) begin failures++; $display("FAIL break_count got=%0d exp=1", pops_a.size()); end
    if (head_a(0) !== {3'b110, 8'h00}) begin failures++; $display("FAIL break_entry got=%h exp=%h", head_a(0), {3'b110, 8'h00}); end
  endtask

  task automatic test_glitch;
    pops_a.delete();
    rx_a = 1'b0;
    repeat (60) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * 10 * BIT) @(negedge clk);
    checks += 2;
    if (pops_a.size() !== 0) begin failures++; $display("FAIL glitch_count got=%0d exp=0", pops_a.size()); end
    if (lvl_a !== 3'd0) begin failures++; $display("FAIL glitch_level got=%0d exp=0", lvl_a); end
  endtask

  task automatic test_back_to_back;
    pops_a.delete();
    rdy_a = 1'b0;
    ovr_a = 0;
    for (int i = 1; i <= 5; i++) send_a(8'(i), 1'b1);
    repeat (100) @(negedge clk);
    checks += 2;
    if (lvl_a !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", lvl_a); end
    if (ovr_a !== 1) begin failures++; $display("FAIL overrun_pulses got=%0d exp=1", ovr_a); end
    rdy_a = 1'b1;
    repeat (10) @(negedge clk);
    checks += 2;
    if (pops_a.size() !== 4) begin failures++; $display("FAIL drain_count got=%0d exp=4", pops_a.size()); end
    if (lvl_a !== 3'd0) begin failures++; $display("FAIL drain_level got=%0d exp=0", lvl_a); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (head_a(i) !== {3'b000, 8'(i + 1)}) begin failures++; $display("FAIL drain_%0d got=%h exp=%h", i, head_a(i), {3'b000, 8'(i + 1)}); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    d = 8'h55;
    pops_a.delete();
    rdy_a = 1'b1;
    rx_a = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_a = d[i];
      repeat (BIT) @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rx_a = 1'b1;
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    send_a(8'h12, 1'b1);
    repeat (100) @(negedge clk);
    checks += 2;
    if (pops_a.size() !== 1) begin failures++; $display("FAIL resetmid_count got=%0d exp=1", pops_a.size()); end
    if (head_a(0) !== {3'b000, 8'h12}) begin failures++; $display("FAIL resetmid_entry got=%h exp=%h", head_a(0), {3'b000, 8'h12}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
